// File: rtl/dec_arb_pkg.sv
// Shared constants and types for the decoder round-robin arbiter.
// Sized for the 16-output one-hot decoder it fronts.
package dec_arb_pkg;

   localparam int unsigned N_REQ = 16;
   localparam int unsigned SEL_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/dec_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping 15 -> 0.
// Rotates so ptr lands at bit 0, priority-encodes, then rotates the index back.
module rr_pick
   import dec_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] idx,
   output logic             any
);

   logic [N_REQ-1:0] rot;
   logic [SEL_W-1:0] enc;

   always_comb begin
      rot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rot[i] = req[SEL_W'(i) + ptr];
      end
   end

   // Scan high to low so the lowest set bit wins.
   always_comb begin
      enc = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            enc = SEL_W'(i);
         end
      end
   end

   assign idx = enc + ptr;
   assign any = |req;

endmodule

// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter that owns the 16-way one-hot decoder's select/enable.
// Grants last at most HOLD_MAX cycles and are followed by a fixed two-cycle quiet period.
module dec_rr_arbiter
   import dec_arb_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [SEL_W-1:0] sel,
   output logic             sel_vld,
   output logic [N_REQ-1:0] gnt
);

   localparam int unsigned CntW = $clog2(HOLD_MAX + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(HOLD_MAX);

   arb_state_t       state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             sel_vld_q, sel_vld_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;

   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;
   logic             release_c;

   rr_pick u_rr_pick (
      .req (req),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign release_c = done | ~req[sel_q] | (cnt_q == CntMax);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      sel_vld_d = sel_vld_q;
      gnt_d     = gnt_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d   = GRANT;
               sel_d     = pick_idx;
               sel_vld_d = 1'b1;
               gnt_d     = {{(N_REQ - 1){1'b0}}, 1'b1} << pick_idx;
               cnt_d     = CntW'(1);
            end
         end
         GRANT: begin
            if (release_c) begin
               // sel is left as-is; only the enable and one-hot drop.
               state_d   = GAP;
               ptr_d     = sel_q + SEL_W'(1);
               sel_vld_d = 1'b0;
               gnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            sel_vld_d = 1'b0;
            gnt_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         sel_q     <= '0;
         cnt_q     <= '0;
         sel_vld_q <= 1'b0;
         gnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         sel_vld_q <= sel_vld_d;
         gnt_q     <= gnt_d;
      end
   end

   assign sel     = sel_q;
   assign sel_vld = sel_vld_q;
   assign gnt     = gnt_q;

endmodule
